// File: rtl/axi_addr_arbiter.sv
// axi_addr_arbiter
//   Merges the AXI AW and AR address channels into one registered command
//   stream for the DDR2 controller command queue. Reads win by default. A
//   starvation counter forces a write grant after WR_STARVE_LIMIT consecutive
//   read grants taken while a write was eligible. An outstanding-write counter
//   keeps AW commands from running more than MAX_WR_OUTSTANDING bursts ahead
//   of their write data.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   aw_* / ar_*         AXI write / read address channels (slave side)
//   wlast_done          pulse: W beat with wlast accepted this cycle
//   cmd_*               merged command stream (valid/ready, one register slot)
//   wr_outstanding      accepted AW bursts still waiting for their wlast
module axi_addr_arbiter #(
  parameter int ADDR_WIDTH         = 32,
  parameter int ID_WIDTH           = 4,
  parameter int ADDR_LEN           = 4,
  parameter int WR_STARVE_LIMIT    = 4,
  parameter int MAX_WR_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  aw_valid,
  output logic                  aw_ready,
  input  logic [ID_WIDTH-1:0]   aw_id,
  input  logic [ADDR_WIDTH-1:0] aw_addr,
  input  logic [ADDR_LEN-1:0]   aw_len,
  input  logic [2:0]            aw_size,
  input  logic [1:0]            aw_burst,
  input  logic                  ar_valid,
  output logic                  ar_ready,
  input  logic [ID_WIDTH-1:0]   ar_id,
  input  logic [ADDR_WIDTH-1:0] ar_addr,
  input  logic [ADDR_LEN-1:0]   ar_len,
  input  logic [2:0]            ar_size,
  input  logic [1:0]            ar_burst,
  input  logic                  wlast_done,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  cmd_write,
  output logic [ID_WIDTH-1:0]   cmd_id,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [ADDR_LEN-1:0]   cmd_len,
  output logic [2:0]            cmd_size,
  output logic [1:0]            cmd_burst,
  output logic [3:0]            wr_outstanding
);

  localparam logic [3:0] STARVE_MAX = 4'(WR_STARVE_LIMIT);
  localparam logic [3:0] WR_MAX     = 4'(MAX_WR_OUTSTANDING);

  logic [3:0] starve_cnt;
  logic       slot_free, aw_elig, ar_elig, force_w;
  logic       grant_aw, grant_ar, wr_dec;

  always_comb begin
    slot_free = !cmd_valid || cmd_ready;
    aw_elig   = aw_valid && (wr_outstanding < WR_MAX);
    ar_elig   = ar_valid;
    force_w   = aw_elig && (starve_cnt == STARVE_MAX);
    // rst gates the readies so no handshake can complete while in reset.
    grant_aw  = !rst && slot_free && aw_elig && (force_w || !ar_elig);
    grant_ar  = !rst && slot_free && ar_elig && !grant_aw;
    // A wlast with nothing outstanding is a protocol error; ignore it.
    wr_dec    = wlast_done && (wr_outstanding != 4'd0);
  end

  assign aw_ready = grant_aw;
  assign ar_ready = grant_ar;

  // Output slot: a grant always refills it (slot_free guarantees the old
  // command is gone or leaving this edge), so back-to-back has no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_write <= 1'b0;
      cmd_id    <= '0;
      cmd_addr  <= '0;
      cmd_len   <= '0;
      cmd_size  <= '0;
      cmd_burst <= '0;
    end else if (grant_aw) begin
      cmd_valid <= 1'b1;
      cmd_write <= 1'b1;
      cmd_id    <= aw_id;
      cmd_addr  <= aw_addr;
      cmd_len   <= aw_len;
      cmd_size  <= aw_size;
      cmd_burst <= aw_burst;
    end else if (grant_ar) begin
      cmd_valid <= 1'b1;
      cmd_write <= 1'b0;
      cmd_id    <= ar_id;
      cmd_addr  <= ar_addr;
      cmd_len   <= ar_len;
      cmd_size  <= ar_size;
      cmd_burst <= ar_burst;
    end else if (cmd_ready) begin
      cmd_valid <= 1'b0;
    end
  end

  // Counts reads that overtook an eligible write; any write grant or the
  // write side going ineligible restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_aw || !aw_elig) begin
      starve_cnt <= '0;
    end else if (grant_ar && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_outstanding <= '0;
    end else begin
      case ({grant_aw, wr_dec})
        2'b10:   wr_outstanding <= wr_outstanding + 4'd1;
        2'b01:   wr_outstanding <= wr_outstanding - 4'd1;
        default: wr_outstanding <= wr_outstanding;
      endcase
    end
  end

endmodule
